// File: rtl/finv_seq.sv
// rtl/finv_seq.sv - sequential reciprocal (table seed + 2 Newton-Raphson steps); FINV_SEQ_EXACT_EN adds an exact RNE fix-up
module finv_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_x,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] y,
  output logic        ovf,
  output logic        udf
);

`ifdef FINV_SEQ_EXACT_EN
  typedef enum logic [2:0] {IDLE, SEED, MUL_A, MUL_B, ROUND, FIX_A, FIX_B, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, SEED, MUL_A, MUL_B, ROUND, DONE} state_t;
`endif

  state_t state_q, state_d;

  logic        sign_q;
  logic [7:0]  exp_q;
  logic [22:0] man_q;
  logic [31:0] r_q;         // reciprocal estimate, Q1.31
  logic [31:0] t_q;         // x*r, Q2.30
  logic        it_q;
  logic [31:0] mul_a, mul_b;
  logic [63:0] prod;
  logic [31:0] two_minus_t;
  logic [31:0] mant_fx;     // 1.m as Q1.31
  logic [23:0] mi;          // 1.m as integer
  logic [24:0] q_round;     // rounded quotient; bit 24 set means exactly 1.0
  logic        round_up;
  logic [7:0]  in_e;
  logic [22:0] in_m;
  logic        sp_zero, sp_inf, sp_udf, is_special;
  logic        unused_prod;

`ifdef FINV_SEQ_EXACT_EN
  logic [24:0]        q_q;
  logic [24:0]        q_fix;
  logic signed [50:0] rho_q;  // 2^48 - 2*Mi*Qi: remainder against the half-ulp midpoint
  logic signed [50:0] mi_s;
`endif

  // Seed ROM: rounded 1/(1.m) at the middle of each of 256 intervals, Q0.12
  logic [11:0] seed_tab [256];
  for (genvar i = 0; i < 256; i++) begin : g_seed
    localparam int unsigned DEN = 513 + 2 * i;
    assign seed_tab[i] = 12'((((1 << 22) / DEN) + 1) / 2);
  end

  assign in_e        = in_x[30:23];
  assign in_m        = in_x[22:0];
  assign sp_zero     = (in_e == 8'd0);
  assign sp_inf      = (in_e == 8'hFF);
  assign sp_udf      = ((in_m == 23'd0) && (in_e >= 8'd254)) || ((in_m != 23'd0) && (in_e >= 8'd253));
  assign is_special  = sp_zero | sp_inf | sp_udf;

  assign mant_fx     = {1'b1, man_q, 8'h00};
  assign mi          = {1'b1, man_q};
  assign two_minus_t = 32'h8000_0000 - t_q;
  assign prod        = {32'd0, mul_a} * {32'd0, mul_b};
  assign unused_prod = ^prod[29:0];

  assign round_up = r_q[6] & ((|r_q[5:0]) | r_q[7]);
  assign q_round  = ((man_q == 23'd0) || r_q[31]) ? 25'h100_0000
                                                   : {1'b0, r_q[30:7]} + {24'd0, round_up};

  function automatic logic [31:0] pack(input logic s, input logic [7:0] e, input logic [24:0] q);
    logic [7:0] be;
    be = q[24] ? 8'(9'd254 - {1'b0, e}) : 8'(9'd253 - {1'b0, e});
    return {s, be, q[24] ? 23'd0 : q[22:0]};
  endfunction

  // Operand select for the single shared multiplier
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_q)
      MUL_A: begin mul_a = mant_fx; mul_b = r_q; end
      MUL_B: begin mul_a = r_q;     mul_b = two_minus_t; end
`ifdef FINV_SEQ_EXACT_EN
      FIX_A: begin mul_a = {7'd0, q_q}; mul_b = {8'd0, mi}; end
`endif
      default: ;
    endcase
  end

`ifdef FINV_SEQ_EXACT_EN
  assign mi_s = $signed({27'd0, mi});

  // Step the quotient by one ulp toward the true reciprocal when past the midpoint
  always_comb begin
    q_fix = q_q;
    if (rho_q > mi_s)       q_fix = q_q + 25'd1;
    else if (rho_q < -mi_s) q_fix = q_q - 25'd1;
  end
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake outputs
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = is_special ? DONE : SEED;
      end
      SEED:  state_d = MUL_A;
      MUL_A: state_d = MUL_B;
      MUL_B: state_d = it_q ? ROUND : MUL_A;
`ifdef FINV_SEQ_EXACT_EN
      ROUND: state_d = FIX_A;
      FIX_A: state_d = FIX_B;
      FIX_B: state_d = DONE;
`else
      ROUND: state_d = DONE;
`endif
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: capture, seed, iterate, round, and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q <= 1'b0;
      exp_q  <= '0;
      man_q  <= '0;
      r_q    <= '0;
      t_q    <= '0;
      it_q   <= 1'b0;
      y      <= '0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
`ifdef FINV_SEQ_EXACT_EN
      q_q    <= '0;
      rho_q  <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          sign_q <= in_x[31];
          exp_q  <= in_e;
          man_q  <= in_m;
          ovf    <= sp_zero;
          udf    <= ~sp_zero & ~sp_inf & sp_udf;
          if (sp_zero)      y <= {in_x[31], 8'hFF, 23'd0};
          else if (is_special) y <= {in_x[31], 31'd0};
        end
        SEED: begin
          r_q  <= {1'b0, seed_tab[man_q[22:15]], 19'd0};
          it_q <= 1'b0;
        end
        MUL_A: t_q <= prod[63:32];
        MUL_B: begin
          r_q  <= prod[61:30];
          it_q <= 1'b1;
        end
`ifdef FINV_SEQ_EXACT_EN
        ROUND: q_q <= q_round;
        FIX_A: rho_q <= 51'sh1_0000_0000_0000 - $signed({2'b00, prod[47:0], 1'b0});
        FIX_B: y <= pack(sign_q, exp_q, q_fix);
`else
        ROUND: y <= pack(sign_q, exp_q, q_round);
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_finv_seq.sv
// tb/tb_finv_seq.sv - self-checking bench for finv_seq (directed cases plus random sweep vs real-arithmetic model)
module tb_finv_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] y;
  logic        ovf;
  logic        udf;

  int vectors = 0;
  int miscompares = 0;

`ifdef FINV_SEQ_EXACT_EN
  localparam int TOL      = 0;
  localparam int LAT_NORM = 9;   // eight processing states, then DONE
`else
  localparam int TOL      = 1;
  localparam int LAT_NORM = 7;   // SEED, four multiplies, ROUND, then DONE
`endif
  localparam int LAT_SPEC = 1;

  finv_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y),
    .ovf       (ovf),
    .udf       (udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic chk_tol(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    logic [31:0] diff;
    diff = (obs > exp_v) ? obs - exp_v : exp_v - obs;
    vectors++;
    assert (!$isunknown(obs) && diff <= 32'(TOL)) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (+/-%0d)", tag, obs, exp_v, TOL);
    end
  endtask

  // Reference: 1/x from real arithmetic, rounded to nearest, special cases from the range rules
  function automatic void ref_model(input logic [31:0] x, output logic [31:0] yr,
                                    output logic o, output logic u, output logic special);
    logic       s;
    int         e, m, qi, be;
    real        mv, q;
    s = x[31];
    e = int'(x[30:23]);
    m = int'(x[22:0]);
    o = 1'b0;
    u = 1'b0;
    special = 1'b1;
    if (e == 0) begin
      yr = {s, 8'hFF, 23'd0};
      o  = 1'b1;
    end else if (e == 255) begin
      yr = {s, 31'd0};
    end else if ((m == 0 && e >= 254) || (m != 0 && e >= 253)) begin
      yr = {s, 31'd0};
      u  = 1'b1;
    end else begin
      special = 1'b0;
      mv = 1.0 + real'(m) / 8388608.0;
      q  = 16777216.0 / mv;
      qi = $rtoi(q);
      if (q - real'(qi) > 0.5) qi++;
      be = 253 - e;
      if (qi >= 16777216) begin
        qi = qi / 2;
        be++;
      end
      yr = {s, 8'(be), 23'(qi)};
    end
  endfunction

  // One full operation with out_ready already high; returns result and cycles to out_valid
  task automatic do_op(input logic [31:0] x, output logic [31:0] yo, output logic oo,
                       output logic uo, output int lat);
    @(negedge clk);
    chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
    in_x = x;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_x = $urandom;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    yo = y;
    oo = ovf;
    uo = udf;
    @(negedge clk);
    chk("idle_after_xfer", {30'd0, in_ready, out_valid}, 32'b10);
  endtask

  initial begin
    logic [31:0] yo, yr, x;
    logic        oo, uo, o_r, u_r, sp;
    int          lat;

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    in_x = '0;
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_y", y, 32'd0);
    chk("rst_flags", {30'd0, ovf, udf}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;

    do_op(32'h3F80_0000, yo, oo, uo, lat);
    chk("one_y", yo, 32'h3F80_0000);
    chk("one_flags", {30'd0, oo, uo}, 32'd0);
    chk("one_lat", 32'(lat), 32'(LAT_NORM));

    do_op(32'hC000_0000, yo, oo, uo, lat);
    chk("neg_two_y", yo, 32'hBF00_0000);

    do_op(32'h4040_0000, yo, oo, uo, lat);
    chk_tol("three_y", yo, 32'h3EAA_AAAB);
    chk("three_flags", {30'd0, oo, uo}, 32'd0);

    do_op(32'h0000_0000, yo, oo, uo, lat);
    chk("zero_y", yo, 32'h7F80_0000);
    chk("zero_flags", {30'd0, oo, uo}, 32'b10);
    chk("zero_lat", 32'(lat), 32'(LAT_SPEC));

    do_op(32'hFF80_0000, yo, oo, uo, lat);
    chk("ninf_y", yo, 32'h8000_0000);
    chk("ninf_flags", {30'd0, oo, uo}, 32'd0);
    chk("ninf_lat", 32'(lat), 32'(LAT_SPEC));

    do_op(32'hFF00_0000, yo, oo, uo, lat);
    chk("big_y", yo, 32'h8000_0000);
    chk("big_flags", {30'd0, oo, uo}, 32'b01);

    // Backpressure: result held, input side closed, stray in_valid ignored
    out_ready = 1'b0;
    @(negedge clk);
    in_x = 32'h4080_0000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("bp_lat", 32'(lat), 32'(LAT_NORM));
    for (int k = 0; k < 5; k++) begin
      chk("bp_y", y, 32'h3E80_0000);
      chk("bp_hs", {30'd0, out_valid, in_ready}, 32'b10);
      in_valid = (k == 2);
      in_x = 32'h3F80_0000;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("bp_flags", {30'd0, ovf, udf}, 32'd0);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_xfer", {30'd0, in_ready, out_valid}, 32'b10);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_no_extra", {31'd0, out_valid}, 32'd0);
    end

    // Reset in the middle of an operation
    @(negedge clk);
    in_x = 32'h4040_0000;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_y", y, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    do_op(32'h4000_0000, yo, oo, uo, lat);
    chk("after_rst_y", yo, 32'h3F00_0000);
    chk("after_rst_lat", 32'(lat), 32'(LAT_NORM));

    // Random sweep against the reference model
    for (int i = 0; i < 1500; i++) begin
      x = $urandom;
      if ($urandom_range(0, 15) == 0) x[22:0] = 23'd0;
      if ($urandom_range(0, 15) == 0) x[30:23] = 8'($urandom_range(250, 255));
      if ($urandom_range(0, 31) == 0) x[30:23] = 8'd0;
      ref_model(x, yr, o_r, u_r, sp);
      do_op(x, yo, oo, uo, lat);
      chk("rnd_flags", {30'd0, oo, uo}, {30'd0, o_r, u_r});
      chk("rnd_lat", 32'(lat), sp ? 32'(LAT_SPEC) : 32'(LAT_NORM));
      if (sp) chk("rnd_special_y", yo, yr);
      else    chk_tol("rnd_y", yo, yr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
